fetch_ctrl: RTL and testbench

- Sequences instruction fetch between the PC register and the instruction memory port.
- Issues one request at a time over a req/gnt/rvalid handshake, buffers one returned instruction, and applies decode back-pressure.
- Arbitrates the redirect sources (trap over branch/jump) and discards the stale in-flight response after a redirect.
- Sits between the fetch PC logic, the imem interface and decode.

---
 rtl/fetch_ctrl.sv | 101 ++++++++++
 tb/tb_fetch_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: one outstanding imem request, one-entry output buffer, trap/branch redirect with stale-response discard.
// First insn_valid_o three cycles after reset release; no request is issued while decode stalls a full buffer.
module fetch_ctrl #(
  parameter int                AWIDTH         = 32,
  parameter int                DWIDTH         = 32,
  parameter logic [31:0]       IMEM_BASE_ADDR = 32'h0100_0000,
  parameter logic [AWIDTH-1:0] RESET_PC       = AWIDTH'(IMEM_BASE_ADDR)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_o,
  output logic [AWIDTH-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [DWIDTH-1:0] imem_rdata_i,
  input  logic              redirect_valid_i,
  input  logic [AWIDTH-1:0] redirect_pc_i,
  input  logic              trap_valid_i,
  input  logic [AWIDTH-1:0] trap_pc_i,
  input  logic              stall_i,
  output logic              insn_valid_o,
  output logic [DWIDTH-1:0] insn_o,
  output logic [AWIDTH-1:0] pc_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t            state;
  logic [AWIDTH-1:0] fetch_pc;
  logic              discard;

  logic              buf_free;
  logic              handshake;
  logic              redir;
  logic [AWIDTH-1:0] redir_sel;
  logic [AWIDTH-1:0] redir_target;
  logic              in_flight;

  // Requesting only into a free buffer guarantees the response always has somewhere to land.
  assign buf_free    = !insn_valid_o || !stall_i;
  assign imem_req_o  = (state == REQ) && buf_free;
  assign imem_addr_o = fetch_pc;
  assign handshake   = imem_req_o && imem_gnt_i;

  assign redir        = (trap_valid_i || redirect_valid_i) && (state != IDLE);
  assign redir_sel    = trap_valid_i ? trap_pc_i : redirect_pc_i;
  assign redir_target = redir_sel & ~AWIDTH'(3);

  // A request is still owed a response after this edge; its data must be dropped on arrival.
  assign in_flight = ((state == WAIT) && !imem_rvalid_i) || ((state == REQ) && handshake);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      fetch_pc     <= RESET_PC;
      discard      <= 1'b0;
      insn_valid_o <= 1'b0;
      insn_o       <= '0;
      pc_o         <= RESET_PC;
    end else begin
      if (insn_valid_o && !stall_i) begin
        insn_valid_o <= 1'b0;
      end

      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (handshake) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid_i) begin
            state   <= REQ;
            discard <= 1'b0;
            if (!discard && !redir) begin
              insn_o       <= imem_rdata_i;
              pc_o         <= fetch_pc;
              insn_valid_o <= 1'b1;
              fetch_pc     <= fetch_pc + AWIDTH'(4);
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (redir) begin
        fetch_pc     <= redir_target;
        insn_valid_o <= 1'b0;
        if (in_flight) begin
          discard <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: behavioural imem with programmable latency, scripted redirect/stall/reset scenarios, scoreboard of delivered instructions.
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        redirect_valid_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        trap_valid_i = 1'b0;
  logic [31:0] trap_pc_i = '0;
  logic        stall_i = 1'b0;
  logic        insn_valid_o;
  logic [31:0] insn_o;
  logic [31:0] pc_o;

  fetch_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .imem_req_o       (imem_req_o),
    .imem_addr_o      (imem_addr_o),
    .imem_gnt_i       (imem_gnt_i),
    .imem_rvalid_i    (imem_rvalid_i),
    .imem_rdata_i     (imem_rdata_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .trap_valid_i     (trap_valid_i),
    .trap_pc_i        (trap_pc_i),
    .stall_i          (stall_i),
    .insn_valid_o     (insn_valid_o),
    .insn_o           (insn_o),
    .pc_o             (pc_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic        gnt_en = 1'b0;
  int          lat = 1;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pend_cnt = 0;
  logic        prev_valid = 1'b0;
  logic        prev_stall = 1'b0;
  exp_t        e;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d, t=%0t)", tag, got, exp, cyc, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic expect_insn(input logic [31:0] pc, input int c);
    exp_t x;
    x.pc   = pc;
    x.insn = mem_word(pc);
    x.cyc  = c;
    sb.push_back(x);
  endtask

  // Cycle 0 is the first cycle with rst low.
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  // Memory: samples the handshake mid-cycle and answers lat cycles later, ignoring reset.
  always begin
    @(negedge clk);
    #2;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = $urandom;
    if (pend) begin
      if (pend_cnt == 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_word(pend_addr);
        pend          = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    imem_gnt_i = gnt_en;
    if (imem_req_o && imem_gnt_i) begin
      check("one_outstanding", pend, 1'b0);
      pend      = 1'b1;
      pend_addr = imem_addr_o;
      pend_cnt  = lat - 1;
    end
  end

  // A buffer entry is new unless it was held by a stall in the previous cycle.
  always begin
    @(negedge clk);
    #1;
    if (!rst && insn_valid_o && !(prev_valid && prev_stall)) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_depth", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        check("sb_pc", pc_o, e.pc);
        check("sb_insn", insn_o, e.insn);
        check("sb_cyc", cyc, e.cyc);
      end
    end
    #2;
    prev_valid = rst ? 1'b0 : insn_valid_o;
    prev_stall = stall_i;
  end

  task automatic to_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    redirect_valid_i = 1'b0;
    trap_valid_i = 1'b0;
    stall_i = 1'b0;
    gnt_en = 1'b0;
    lat = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_req", imem_req_o, 1'b0);
    check("rst_valid", insn_valid_o, 1'b0);
    check("rst_insn", insn_o, 32'h0);
    check("rst_pc", pc_o, RESET_PC);

    // Back-to-back fetch, then a four-cycle stall on a full buffer.
    do_reset();
    gnt_en = 1'b1;
    expect_insn(RESET_PC, 3);
    expect_insn(RESET_PC + 4, 5);
    expect_insn(RESET_PC + 8, 7);
    expect_insn(RESET_PC + 12, 9);
    #1 check("idle_req", imem_req_o, 1'b0);
    to_cyc(1); #1 check("c1_req", imem_req_o, 1'b1); check("c1_addr", imem_addr_o, RESET_PC);
    to_cyc(2); #1 check("c2_wait_req", imem_req_o, 1'b0);
    to_cyc(3); #1 check("c3_addr", imem_addr_o, RESET_PC + 4);
    to_cyc(5); #1 check("c5_addr", imem_addr_o, RESET_PC + 8);
    for (int k = 9; k <= 12; k++) begin
      to_cyc(k);
      stall_i = 1'b1;
      #1;
      check("stall_req", imem_req_o, 1'b0);
      check("stall_valid", insn_valid_o, 1'b1);
      check("stall_pc", pc_o, RESET_PC + 12);
      check("stall_insn", insn_o, mem_word(RESET_PC + 12));
    end
    to_cyc(13); stall_i = 1'b0; expect_insn(RESET_PC + 16, 15);
    #1 check("resume_req", imem_req_o, 1'b1); check("resume_addr", imem_addr_o, RESET_PC + 16);
    to_cyc(15); gnt_en = 1'b0;
    to_cyc(16); #1 check("nognt_req", imem_req_o, 1'b1); check("nognt_addr", imem_addr_o, RESET_PC + 20);

    // Branch redirect while waiting: the late response is discarded.
    do_reset();
    gnt_en = 1'b1; lat = 3;
    to_cyc(2); redirect_valid_i = 1'b1; redirect_pc_i = 32'h0100_0100; gnt_en = 1'b0;
    to_cyc(3); redirect_valid_i = 1'b0;
    #1 check("disc_valid3", insn_valid_o, 1'b0); check("disc_req3", imem_req_o, 1'b0);
    to_cyc(4); #1 check("disc_req4", imem_req_o, 1'b0);
    to_cyc(5); gnt_en = 1'b1; expect_insn(32'h0100_0100, 9);
    #1 check("disc_valid5", insn_valid_o, 1'b0); check("disc_addr5", imem_addr_o, 32'h0100_0100);
    to_cyc(6); gnt_en = 1'b0;
    to_cyc(10);

    // Trap wins over a simultaneous branch.
    do_reset();
    to_cyc(1);
    trap_valid_i = 1'b1; trap_pc_i = 32'h0000_0200;
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h0100_0040;
    to_cyc(2); trap_valid_i = 1'b0; redirect_valid_i = 1'b0; gnt_en = 1'b1;
    expect_insn(32'h0000_0200, 4);
    #1 check("trap_addr", imem_addr_o, 32'h0000_0200);
    to_cyc(3); gnt_en = 1'b0;
    to_cyc(5);

    // Misaligned target in REQ without grant: aligned, nothing discarded.
    do_reset();
    to_cyc(1); redirect_valid_i = 1'b1; redirect_pc_i = 32'h0100_0103;
    to_cyc(2); redirect_valid_i = 1'b0; gnt_en = 1'b1;
    expect_insn(32'h0100_0100, 4);
    #1 check("align_addr", imem_addr_o, 32'h0100_0100);
    to_cyc(3); gnt_en = 1'b0;
    to_cyc(5);

    // Redirect on the grant cycle: the granted response is discarded.
    do_reset();
    gnt_en = 1'b1; lat = 2;
    to_cyc(1); redirect_valid_i = 1'b1; redirect_pc_i = 32'h0100_0200;
    #1 check("hsredir_addr", imem_addr_o, RESET_PC);
    to_cyc(2); redirect_valid_i = 1'b0; gnt_en = 1'b0;
    #1 check("hsredir_wait", imem_req_o, 1'b0);
    to_cyc(4); #1 check("hsredir_req", imem_req_o, 1'b1); check("hsredir_addr4", imem_addr_o, 32'h0100_0200);
    check("hsredir_valid", insn_valid_o, 1'b0);
    to_cyc(6);

    // Redirect coinciding with rvalid: response dropped, no discard left behind.
    do_reset();
    gnt_en = 1'b1;
    to_cyc(2); redirect_valid_i = 1'b1; redirect_pc_i = 32'h0100_0300; gnt_en = 1'b0;
    to_cyc(3); redirect_valid_i = 1'b0; gnt_en = 1'b1;
    expect_insn(32'h0100_0300, 5);
    #1 check("coinc_valid", insn_valid_o, 1'b0); check("coinc_addr", imem_addr_o, 32'h0100_0300);
    to_cyc(4); gnt_en = 1'b0;
    to_cyc(6);

    // Redirect flushes a stalled buffer.
    do_reset();
    gnt_en = 1'b1;
    expect_insn(RESET_PC, 3);
    to_cyc(3); stall_i = 1'b1; gnt_en = 1'b0;
    #1 check("fl_req3", imem_req_o, 1'b0); check("fl_valid3", insn_valid_o, 1'b1);
    to_cyc(4); redirect_valid_i = 1'b1; redirect_pc_i = 32'h0100_0400;
    to_cyc(5); redirect_valid_i = 1'b0; stall_i = 1'b0;
    #1 check("fl_valid5", insn_valid_o, 1'b0); check("fl_req5", imem_req_o, 1'b1);
    check("fl_addr5", imem_addr_o, 32'h0100_0400);
    to_cyc(6);

    // PC wrap, then reset mid-WAIT with a late response.
    do_reset();
    to_cyc(1); redirect_valid_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    to_cyc(2); redirect_valid_i = 1'b0; gnt_en = 1'b1;
    expect_insn(32'hFFFF_FFFC, 4);
    #1 check("wrap_addr_hi", imem_addr_o, 32'hFFFF_FFFC);
    to_cyc(3); lat = 2;
    to_cyc(4); #1 check("wrap_req", imem_req_o, 1'b1); check("wrap_addr0", imem_addr_o, 32'h0);
    to_cyc(5); rst = 1'b1; gnt_en = 1'b0;
    #1 check("pre_rst_wait", imem_req_o, 1'b0);
    @(negedge clk); rst = 1'b0;
    #1 check("mid_rst_req", imem_req_o, 1'b0); check("mid_rst_valid", insn_valid_o, 1'b0);
    check("mid_rst_pc", pc_o, RESET_PC);
    @(negedge clk);
    #1 check("post_rst_req", imem_req_o, 1'b1); check("post_rst_addr", imem_addr_o, RESET_PC);
    check("late_rvalid_valid", insn_valid_o, 1'b0);
    @(negedge clk);
    #1 check("late_rvalid_valid2", insn_valid_o, 1'b0);
    repeat (3) @(negedge clk);

    check("sb_drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
